// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes them to imem from
// address 0, holding the core in reset until the load completes. Trailer checksum: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int INST_SIZE  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_SIZE-1:0]  imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            dbg_state
);
    // Handshake: a byte moves on a rising edge where in_valid && in_ready; otherwise it is held.
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WRITE = 2'd2, RUN = 2'd3} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [INST_SIZE-1:0]    r_wdata;
    logic                    r_core_rst;
    logic                    r_done;
    logic                    r_err;
    logic [ADDR_WIDTH:0]     r_len;
    logic [ADDR_WIDTH:0]     r_word_cnt;
    logic [1:0]              r_byte_cnt;
    logic [INST_SIZE-9:0]    r_word;
`ifdef LOADER_CHECKSUM_EN
    logic [INST_SIZE-1:0]    r_sum;
    logic                    r_trailer;
`endif

    logic [INST_SIZE-1:0]    w_full_word;
    logic [ADDR_WIDTH:0]     w_next_cnt;

    assign w_full_word = {in_byte, r_word};
    assign w_next_cnt  = r_word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_trailer  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                // A start in RUN is a reload and follows exactly the IDLE rules.
                IDLE, RUN: begin
                    if (start) begin
                        if (len_words > MAX_LEN) begin
                            r_err      <= 1'b1;
                            r_state    <= IDLE;
                            r_core_rst <= 1'b1;
                        end else begin
                            r_err      <= 1'b0;
                            r_len      <= len_words;
                            r_word_cnt <= '0;
                            r_byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_sum      <= '0;
                            r_trailer  <= (len_words == '0);
                            r_state    <= LOAD;
                            r_in_ready <= 1'b1;
                            r_core_rst <= 1'b1;
`else
                            if (len_words == '0) begin
                                r_state    <= RUN;
                                r_done     <= 1'b1;
                                r_core_rst <= 1'b0;
                            end else begin
                                r_state    <= LOAD;
                                r_in_ready <= 1'b1;
                                r_core_rst <= 1'b1;
                            end
`endif
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0:    r_word[7:0]   <= in_byte;
                            2'd1:    r_word[15:8]  <= in_byte;
                            2'd2:    r_word[23:16] <= in_byte;
                            default: ;
                        endcase
                        if (r_byte_cnt == 2'd3) begin
                            r_in_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                            if (r_trailer) begin
                                if (w_full_word == r_sum) begin
                                    r_state    <= RUN;
                                    r_done     <= 1'b1;
                                    r_core_rst <= 1'b0;
                                end else begin
                                    r_state <= IDLE;
                                    r_err   <= 1'b1;
                                end
                            end else begin
                                r_state <= WRITE;
                                r_we    <= 1'b1;
                                r_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                                r_wdata <= w_full_word;
                                r_sum   <= r_sum + w_full_word;
                            end
`else
                            r_state <= WRITE;
                            r_we    <= 1'b1;
                            r_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                            r_wdata <= w_full_word;
`endif
                        end
                    end
                end
                WRITE: begin
                    r_word_cnt <= w_next_cnt;
                    r_in_ready <= 1'b1;
                    r_state    <= LOAD;
                    if (w_next_cnt == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                        r_trailer  <= 1'b1;
`else
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst   = r_core_rst;
    assign done       = r_done;
    assign err        = r_err;
    assign dbg_state  = r_state;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time block directly upstream of the pipeline top.
- Accepts a byte stream from a host/bench port and packs it little-endian into 32-bit instruction words.
- Writes each word sequentially into instruction memory from address 0.
- Holds the core in reset until the programmed word count has been written, then releases it.

Parameters:
INST_SIZE, 32, instruction word width; fixed at 32, since packing assumes 4 bytes/word
ADDR_WIDTH, 10, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse: begin a load of len_words words
len_words  input  ADDR_WIDTH+1  number of words to load; sampled only on accepted start
in_valid  input  1  in_byte valid
in_byte  input  8  program byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  word address for the write
imem_wdata  output  INST_SIZE  packed word
core_rst  output  1  active-high reset to the pipeline
done  output  1  one-cycle pulse when the load completes
err  output  1  sticky error flag, cleared by the next accepted start or by rst

Behaviour:
- Reset (async):
  - state=IDLE; core_rst=1; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; done=0; err=0.
  - Byte counter and word counter are 0.
- States: IDLE, LOAD, WRITE, RUN.
- IDLE:
  - start with 1<=len_words<=2**ADDR_WIDTH: latch len, clear counters, clear err, go to LOAD.
  - start with len_words==0: go straight to RUN with a done pulse; memory is untouched.
  - start with len_words>2**ADDR_WIDTH: set err=1, stay in IDLE.
- LOAD:
  - in_ready=1.
  - Byte transfer occurs when in_valid && in_ready.
  - Byte k (k=0..3) goes to word bits [8k+7:8k].
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0; imem_we=1; imem_addr=word counter; imem_wdata=packed word.
  - Next cycle: word counter increments.
  - If the new count equals len: go to RUN and pulse done for 1 cycle.
  - Otherwise return to LOAD.
- Throughput: 5 cycles/word minimum (4 byte cycles + 1 write cycle).
- RUN:
  - core_rst=0 is registered, so it deasserts on the same edge that enters RUN.
  - in_ready=0; input bytes are ignored.
  - start in RUN: reload. core_rst=1 on the next edge, then the IDLE rules above apply (same len checks).
- start while in LOAD or WRITE is ignored.
- in_valid while in_ready=0 causes no transfer; the byte is not consumed.
- Last address written = len-1; imem_addr never wraps within one load.
- rst asserted mid-load: immediate return to reset values. A partial word is discarded and core_rst=1. Already-written memory words are not cleared.
- imem_we deasserts in all states other than WRITE. imem_addr and imem_wdata hold their last values.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word's WRITE, the loader returns to LOAD for 4 additional bytes. These form an expected checksum, packed little-endian and not written to memory.
  - A running 32-bit modulo-2**32 sum of all written words is compared against it.
  - Match: go to RUN with a done pulse.
  - Mismatch: err=1, state=IDLE, core_rst stays 1, no done pulse.
  - len_words==0: expects the checksum 0x00000000 only.
- Undefined: no trailer bytes and no sum logic. Load completes after len words.

Test Plan:
- Reset then start, len_words=1, bytes 13 05 50 00 -> one WRITE with imem_addr=0, imem_wdata=0x00500513; done pulse; core_rst falls on the same edge.
- len_words=3, bytes streamed with in_valid toggling every other cycle -> writes to addr 0,1,2 with correct words; no byte lost or duplicated; in_ready=0 during each WRITE cycle.
- start with len_words=2**ADDR_WIDTH+1 (1025 at default) -> err=1, state stays IDLE, no writes, core_rst=1; a following valid start clears err.
- rst asserted after 2 bytes of word 1 -> outputs return to reset values immediately; a new load from start writes word 0 at addr 0 correctly.
- In RUN, pulse start with len_words=1 -> core_rst re-asserts, new word overwrites addr 0, core_rst falls again.
- LOADER_CHECKSUM_EN, len 2, words 0x00000001 and 0xFFFFFFFF:
  - trailer 0x00000000 -> done, core_rst=0.
  - trailer 0x00000001 -> err=1, core_rst=1.
